// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo counter with run-time maximum, clamp and registered carry-out.
// Optional parallel load is enabled by defining COUNTER_LOAD_EN.
module bcd_mod_counter #(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MIN_VAL = 1,
    parameter int unsigned MAX_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_mode,
    input  logic                tick_in,
    input  logic                up,
    input  logic                down,
    input  logic [MAX_W-1:0]    max_val,
`ifdef COUNTER_LOAD_EN
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_bcd,
    output logic                load_err,
`endif
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                tick_out,
    output logic                at_max
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    // 14 bits hold 9999, the largest four-digit value
    localparam int unsigned VAL_W = (MAX_W > 14) ? MAX_W : 14;
    localparam logic [VAL_W-1:0] MIN_EXT = VAL_W'(MIN_VAL);
    localparam logic [BCD_W-1:0] MIN_BCD = BCD_W'(MIN_VAL);

    function automatic logic [VAL_W-1:0] bcd2bin(input logic [BCD_W-1:0] b);
        logic [VAL_W-1:0] acc;
        acc = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--)
            acc = VAL_W'(acc * VAL_W'(10)) + VAL_W'(b[4*i +: 4]);
        return acc;
    endfunction

    // Digits above DIGITS are dropped so the result is always legal BCD
    function automatic logic [BCD_W-1:0] bin2bcd(input logic [VAL_W-1:0] v);
        logic [VAL_W-1:0] t;
        logic [BCD_W-1:0] r;
        t = v;
        r = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(t % VAL_W'(10));
            t           = t / VAL_W'(10);
        end
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic             c;
        r = b;
        c = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic             c;
        r = b;
        c = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

`ifdef COUNTER_LOAD_EN
    function automatic logic all_bcd(input logic [BCD_W-1:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++)
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    logic             load_err_d;
    logic [VAL_W-1:0] load_val;
`endif

    logic [VAL_W-1:0] cur_val;
    logic [VAL_W-1:0] max_ext;
    logic [BCD_W-1:0] max_bcd;
    logic [BCD_W-1:0] hold_bcd;
    logic [BCD_W-1:0] bcd_d;
    logic             tick_d;

    assign cur_val = bcd2bin(bcd_out);
    assign max_ext = VAL_W'(max_val);
    assign max_bcd = bin2bcd(max_ext);
    assign at_max  = (cur_val == max_ext);

    // Idle value: hold, but pull down to the maximum if it has shrunk below us
    assign hold_bcd = (cur_val > max_ext) ? max_bcd : bcd_out;

    // Next-value selection: load, illegal maximum, then run/adjust
    always_comb begin
        bcd_d  = bcd_out;
        tick_d = 1'b0;
`ifdef COUNTER_LOAD_EN
        load_err_d = 1'b0;
        load_val   = bcd2bin(load_bcd);
        if (load) begin
            if (all_bcd(load_bcd) && (load_val >= MIN_EXT) && (load_val <= max_ext))
                bcd_d = load_bcd;
            else
                load_err_d = 1'b1;
        end else
`endif
        if (max_ext < MIN_EXT) begin
            bcd_d = MIN_BCD;
        end else if (run_mode) begin
            if (tick_in) begin
                if (cur_val >= max_ext) begin
                    bcd_d  = MIN_BCD;
                    tick_d = 1'b1;
                end else begin
                    bcd_d = bcd_inc(bcd_out);
                end
            end else begin
                bcd_d = hold_bcd;
            end
        end else begin
            case ({up, down})
                2'b10:   bcd_d = (cur_val >= max_ext) ? MIN_BCD : bcd_inc(bcd_out);
                2'b01:   bcd_d = ((cur_val <= MIN_EXT) || (cur_val > max_ext)) ? max_bcd
                                                                               : bcd_dec(bcd_out);
                default: bcd_d = hold_bcd;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_out  <= MIN_BCD;
            tick_out <= 1'b0;
`ifdef COUNTER_LOAD_EN
            load_err <= 1'b0;
`endif
        end else begin
            bcd_out  <= bcd_d;
            tick_out <= tick_d;
`ifdef COUNTER_LOAD_EN
            load_err <= load_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Self-checking bench for bcd_mod_counter (DIGITS=2, MIN_VAL=1, MAX_W=5) against an integer model.
module tb_bcd_mod_counter;

    localparam int MIN_V = 1;

    logic       clk = 1'b0;
    logic       rst, run_mode, tick_in, up, down, load;
    logic [4:0] max_val;
    logic [7:0] load_bcd, bcd_out;
    logic       tick_out, at_max;
`ifdef COUNTER_LOAD_EN
    logic       load_err;
`endif

    int m;
    bit mt, me;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_mod_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .run_mode (run_mode),
        .tick_in  (tick_in),
        .up       (up),
        .down     (down),
        .max_val  (max_val),
`ifdef COUNTER_LOAD_EN
        .load     (load),
        .load_bcd (load_bcd),
        .load_err (load_err),
`endif
        .bcd_out  (bcd_out),
        .tick_out (tick_out),
        .at_max   (at_max)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Next value straight from the counting rules, in plain integers
    function automatic void model_next(input int cur, input bit rm, input bit ti, input bit u,
                                       input bit d, input bit ld, input logic [7:0] lb,
                                       input int mx, output int nxt, output bit nt, output bit ne);
        logic [3:0] lo, hi;
        int lv;
        lo  = lb[3:0];
        hi  = lb[7:4];
        lv  = int'(hi) * 10 + int'(lo);
        nxt = cur;
        nt  = 1'b0;
        ne  = 1'b0;
        if (ld) begin
            if (lo <= 4'd9 && hi <= 4'd9 && lv >= MIN_V && lv <= mx) nxt = lv;
            else ne = 1'b1;
        end else if (mx < MIN_V) begin
            nxt = MIN_V;
        end else if (rm) begin
            if (ti) begin
                if (cur >= mx) begin nxt = MIN_V; nt = 1'b1; end
                else nxt = cur + 1;
            end else if (cur > mx) begin
                nxt = mx;
            end
        end else if (u && !d) begin
            nxt = (cur >= mx) ? MIN_V : cur + 1;
        end else if (d && !u) begin
            nxt = (cur <= MIN_V || cur > mx) ? mx : cur - 1;
        end else if (cur > mx) begin
            nxt = mx;
        end
    endfunction

    task automatic step();
        int nx;
        bit nt, ne;
        model_next(m, run_mode, tick_in, up, down, load, load_bcd, int'(max_val), nx, nt, ne);
        @(posedge clk);
        #1;
        m  = nx;
        mt = nt;
        me = ne;
    endtask

    task automatic goto(input int target);
        run_mode = 1'b1;
        max_val  = 5'd31;
        up       = 1'b0;
        down     = 1'b0;
        tick_in  = 1'b1;
        for (int k = 0; k < 100 && m != target; k++) step();
        tick_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run_mode = 1'b1; tick_in = 1'b0; up = 1'b0; down = 1'b0;
        load = 1'b0; load_bcd = 8'h00; max_val = 5'd31;
        m = MIN_V; mt = 1'b0; me = 1'b0;
        #2;
        n_checks++;
        if (bcd_out !== 8'h01 || tick_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: bcd=%h tick=%b expected bcd=01 tick=0", bcd_out, tick_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        n_checks++;
        if (bcd_out !== 8'h01 || tick_out !== 1'b0 || at_max !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: bcd=%h tick=%b at_max=%b expected 01/0/0", bcd_out, tick_out, at_max);
        end
    endtask

    task automatic test_run_wrap();
        run_mode = 1'b1; max_val = 5'd31;
        for (int p = 1; p <= 31; p++) begin
            tick_in = 1'b1;
            step();
            n_checks++;
            if (bcd_out !== to_bcd(m) || tick_out !== mt || at_max !== (m == int'(max_val))) begin
                n_fail++;
                $display("FAIL run_wrap pulse %0d: bcd=%h tick=%b at_max=%b expected %h/%b/%b",
                         p, bcd_out, tick_out, at_max, to_bcd(m), mt, m == int'(max_val));
            end
            tick_in = 1'b0;
            step();
            n_checks++;
            if (bcd_out !== to_bcd(m) || tick_out !== 1'b0) begin
                n_fail++;
                $display("FAIL run_wrap gap %0d: bcd=%h tick=%b expected %h/0", p, bcd_out, tick_out, to_bcd(m));
            end
        end
        n_checks++;
        if (bcd_out !== 8'h01) begin
            n_fail++;
            $display("FAIL run_wrap final: bcd=%h expected 01", bcd_out);
        end
    endtask

    task automatic test_back_to_back();
        goto(30);
        max_val = 5'd2;
        tick_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++;
            if (bcd_out !== to_bcd(m) || tick_out !== mt) begin
                n_fail++;
                $display("FAIL back_to_back %0d: bcd=%h tick=%b expected %h/%b", k, bcd_out, tick_out, to_bcd(m), mt);
            end
        end
        tick_in = 1'b0;
    endtask

    task automatic test_bcd_carry();
        logic [7:0] want [2];
        int         from [2];
        from[0] = 9;  want[0] = 8'h10;
        from[1] = 19; want[1] = 8'h20;
        for (int c = 0; c < 2; c++) begin
            goto(from[c]);
            tick_in = 1'b1;
            step();
            tick_in = 1'b0;
            n_checks++;
            if (bcd_out !== want[c] || bcd_out !== to_bcd(m)) begin
                n_fail++;
                $display("FAIL bcd_carry from %0d: bcd=%h expected %h", from[c], bcd_out, want[c]);
            end
        end
    endtask

    task automatic test_adjust();
        logic [7:0] want [4];
        logic       ud   [4];
        goto(1);
        run_mode = 1'b0; max_val = 5'd29; tick_in = 1'b1;
        want[0] = 8'h29; ud[0] = 1'b0;
        want[1] = 8'h28; ud[1] = 1'b0;
        want[2] = 8'h29; ud[2] = 1'b1;
        want[3] = 8'h01; ud[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            up = ud[k]; down = !ud[k];
            step();
            n_checks++;
            if (bcd_out !== want[k] || bcd_out !== to_bcd(m) || tick_out !== 1'b0) begin
                n_fail++;
                $display("FAIL adjust step %0d: bcd=%h tick=%b expected %h/0", k, bcd_out, tick_out, want[k]);
            end
        end
        up = 1'b0; down = 1'b0; tick_in = 1'b0;
    endtask

    task automatic test_clamp();
        goto(30);
        max_val = 5'd28;
        step();
        n_checks++;
        if (bcd_out !== 8'h28 || at_max !== 1'b1 || tick_out !== 1'b0 || bcd_out !== to_bcd(m)) begin
            n_fail++;
            $display("FAIL clamp: bcd=%h at_max=%b tick=%b expected 28/1/0", bcd_out, at_max, tick_out);
        end
        max_val = 5'd0;
        tick_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (bcd_out !== 8'h01 || tick_out !== 1'b0 || bcd_out !== to_bcd(m)) begin
                n_fail++;
                $display("FAIL illegal_max %0d: bcd=%h tick=%b expected 01/0", k, bcd_out, tick_out);
            end
        end
        tick_in = 1'b0;
        max_val = 5'd31;
    endtask

    task automatic test_async_reset();
        goto(17);
        n_checks++;
        if (bcd_out !== 8'h17) begin
            n_fail++;
            $display("FAIL async_pre: bcd=%h expected 17", bcd_out);
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bcd_out !== 8'h01 || tick_out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: bcd=%h tick=%b expected 01/0", bcd_out, tick_out);
        end
        #1;
        rst = 1'b0;
        m = MIN_V; mt = 1'b0; me = 1'b0;
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        n_checks++;
        if (bcd_out !== 8'h02 || bcd_out !== to_bcd(m)) begin
            n_fail++;
            $display("FAIL async_resume: bcd=%h expected 02", bcd_out);
        end
    endtask

`ifdef COUNTER_LOAD_EN
    task automatic test_load();
        logic [7:0] lv   [4];
        logic [7:0] want [4];
        logic       werr [4];
        goto(5);
        run_mode = 1'b1; max_val = 5'd31; tick_in = 1'b1;
        lv[0] = 8'h15; want[0] = 8'h15; werr[0] = 1'b0;
        lv[1] = 8'h1A; want[1] = 8'h15; werr[1] = 1'b1;
        lv[2] = 8'h32; want[2] = 8'h15; werr[2] = 1'b1;
        lv[3] = 8'h31; want[3] = 8'h31; werr[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            load = 1'b1; load_bcd = lv[k];
            step();
            n_checks++;
            if (bcd_out !== want[k] || load_err !== werr[k] || tick_out !== 1'b0 || bcd_out !== to_bcd(m)) begin
                n_fail++;
                $display("FAIL load %h: bcd=%h err=%b tick=%b expected %h/%b/0",
                         lv[k], bcd_out, load_err, tick_out, want[k], werr[k]);
            end
            load = 1'b0; tick_in = 1'b0;
            step();
            n_checks++;
            if (load_err !== 1'b0) begin
                n_fail++;
                $display("FAIL load_err_pulse %0d: err=%b expected 0", k, load_err);
            end
            tick_in = 1'b1;
        end
        tick_in = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            run_mode = 1'($urandom_range(0, 1));
            tick_in  = 1'($urandom_range(0, 1));
            up       = 1'($urandom_range(0, 1));
            down     = 1'($urandom_range(0, 1));
            max_val  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(20, 31));
`ifdef COUNTER_LOAD_EN
            load     = ($urandom_range(0, 9) == 0);
            load_bcd = ($urandom_range(0, 1) == 1) ? to_bcd(int'($urandom_range(0, 35))) : 8'($urandom);
`endif
            step();
            n_checks++;
            if (bcd_out !== to_bcd(m) || tick_out !== mt || at_max !== (m == int'(max_val))
                || bcd_out[3:0] > 4'd9 || bcd_out[7:4] > 4'd9) begin
                n_fail++;
                $display("FAIL random %0d: bcd=%h tick=%b at_max=%b expected %h/%b/%b",
                         k, bcd_out, tick_out, at_max, to_bcd(m), mt, m == int'(max_val));
            end
`ifdef COUNTER_LOAD_EN
            n_checks++;
            if (load_err !== me) begin
                n_fail++;
                $display("FAIL random_load_err %0d: err=%b expected %b", k, load_err, me);
            end
`endif
        end
        load = 1'b0; up = 1'b0; down = 1'b0; tick_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_wrap();
        test_back_to_back();
        test_bcd_carry();
        test_adjust();
        test_clamp();
        test_async_reset();
`ifdef COUNTER_LOAD_EN
        test_load();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
Parametrised multi-digit BCD modulo counter. It generalises the calendar day/month/hour digit counters into a single block with these properties:
- configurable digit count and minimum value;
- run-time maximum value;
- auto-clamp when the maximum shrinks;
- registered carry-out for cascading.
It sits in the clock/calendar datapath, fed by the lower-order counter's tick and by the user-adjust buttons. Its outputs drive the display decoders.

Parameters:
DIGITS, 2, number of BCD digits (1..4)
MIN_VAL, 1, wrap-to value and reset value (binary, 0..9)
MAX_W, 5, width of max_val in bits (must cover 10^DIGITS-1 or the largest used maximum)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
run_mode  input  1  1 = count on tick_in; 0 = manual adjust with up/down
tick_in  input  1  one-cycle count-enable pulse from the lower-order counter
up  input  1  manual increment request, one cycle, sampled in adjust mode only
down  input  1  manual decrement request, one cycle, sampled in adjust mode only
max_val  input  MAX_W  inclusive maximum, binary, may change any cycle
bcd_out  output  4*DIGITS  counter value, digit 0 in bits [3:0], registered
tick_out  output  1  carry pulse to the next counter, registered
at_max  output  1  combinational, 1 when value == max_val

Behaviour:
- One clock domain. Reset is asynchronous and active-high: rst high forces bcd_out = BCD(MIN_VAL), tick_out = 0, immediately and regardless of clk. Internal state resets with it.
- V = binary value of bcd_out, computed as the sum of digit_i * 10^i. All comparisons use V against max_val, zero-extended to a common width.
- Every digit always holds 0..9. Increment and decrement ripple BCD carry/borrow across digits. A binary +1 on a digit that reads 9 is illegal.
- Run mode (run_mode = 1); up and down are ignored:
  - tick_in = 1 and V >= max_val: next V = MIN_VAL, tick_out = 1 on the next cycle.
  - tick_in = 1 and V < max_val: next V = V + 1, tick_out = 0.
  - tick_in = 0: hold the value, tick_out = 0. If V > max_val, clamp: next V = max_val.
- Adjust mode (run_mode = 0); tick_out is always 0 and tick_in is ignored:
  - {up, down} = 10: if V >= max_val, next V = MIN_VAL; else next V = V + 1.
  - {up, down} = 01: if V <= MIN_VAL, next V = max_val; else if V > max_val, next V = max_val; else next V = V - 1.
  - {up, down} = 00 or 11: hold, then clamp as in run mode.
- Clamp use case: month change 31→28 with day 30 shown. Next cycle shows 28; no tick_out is produced.
- Illegal max_val < MIN_VAL: V is forced to MIN_VAL every cycle and tick_out = 0. The block must not lock up or produce non-BCD digits.
- tick_out is a single-cycle pulse. Latency from tick_in to tick_out is 1 cycle. Consecutive ticks at the wrap point produce consecutive pulses.
- A mode change takes effect on the same edge. No state is carried between modes.
- at_max is decoded from the registered value and the current max_val. It has no extra latency.

Optional Feature:
Macro COUNTER_LOAD_EN.
- Defined:
  - Adds ports load (input 1), load_bcd (input 4*DIGITS) and load_err (output 1, registered, reset 0).
  - load has highest priority over run/adjust and clamp.
  - If every digit is <= 9 and MIN_VAL <= value <= max_val, next bcd_out = load_bcd and load_err = 0.
  - Otherwise the value holds and load_err pulses 1 for one cycle.
  - tick_out = 0 in any load cycle.
- Not defined: these ports do not exist and behaviour is exactly as above.

Test Plan:
- Reset and run: DIGITS=2, MIN_VAL=1, max_val=31, rst pulse. Check bcd_out=0x01, tick_out=0. Then 31 tick_in pulses: bcd_out steps 01..31, and the 31st pulse gives bcd_out=0x01 with tick_out=1 for exactly one cycle.
- BCD carry: from 0x09 one tick gives 0x10. From 0x19 one tick gives 0x20. No non-BCD digit appears at any cycle.
- Adjust down wrap: run_mode=0, V=01, max_val=29, down pulse gives 0x29. Down again gives 0x28. up at 0x29 gives 0x01, with tick_out staying 0 throughout.
- Clamp: V=30, max_val changed 31→28, no events. The next cycle gives 0x28 and at_max=1, with no tick_out.
- Async reset mid-count: assert rst between clk edges at V=0x17. bcd_out goes to 0x01 before the next edge. Deasserting rst then counting resumes from 01.
- COUNTER_LOAD_EN: load 0x15 with max_val=31 gives 0x15, load_err=0. Load 0x1A, or 0x32 with max_val=31: value held and load_err=1 for one cycle. load together with tick_in: load wins and tick_out=0.
